// File: rtl/esm_issue_scheduler.sv
// rtl/esm_issue_scheduler.sv - ESM instruction buffer slot allocator and oldest-ready issue selector.
// Optional sticky protocol-error output enabled by defining ESM_SCHED_ERR_EN.
module esm_issue_scheduler #(
  parameter  int BS    = 16,
  localparam int IDX_W = $clog2(BS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_index,
  input  logic [BS-1:0]    alloc_dep,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [IDX_W-1:0] issue_index,
  input  logic             complete_valid,
  input  logic [IDX_W-1:0] complete_index,
  input  logic             flush,
  output logic [IDX_W:0]   occupancy
`ifdef ESM_SCHED_ERR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {S_FREE, S_WAIT, S_ISSUED} slot_state_e;

  localparam logic [BS-1:0] ONE = BS'(1);

  slot_state_e   state_q [BS];
  slot_state_e   state_d [BS];
  logic [BS-1:0] dep_q   [BS];
  logic [BS-1:0] dep_d   [BS];
  // age_q[i][j] = 1 means slot i was allocated before slot j
  logic [BS-1:0] age_q   [BS];
  logic [BS-1:0] age_d   [BS];

  logic [BS-1:0] free_vec;
  logic [BS-1:0] ready_vec;
  logic [BS-1:0] has_older_ready;
  logic          alloc_fire;
  logic          issue_fire;
  logic          comp_fire;
  logic [BS-1:0] alloc_mask;

  always_comb begin
    free_vec    = '0;
    ready_vec   = '0;
    alloc_index = '0;
    occupancy   = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      free_vec[i]  = (state_q[i] == S_FREE);
      ready_vec[i] = (state_q[i] == S_WAIT) && (dep_q[i] == '0);
      if (state_q[i] == S_FREE) alloc_index = IDX_W'(i);
      occupancy = occupancy + (IDX_W+1)'(state_q[i] != S_FREE);
    end
    alloc_ready = |free_vec;
  end

  always_comb begin
    has_older_ready = '0;
    issue_index     = '0;
    for (int i = 0; i < BS; i++) begin
      for (int j = 0; j < BS; j++) begin
        if (ready_vec[j] && age_q[j][i]) has_older_ready[i] = 1'b1;
      end
      if (ready_vec[i] && !has_older_ready[i]) issue_index = IDX_W'(i);
    end
    issue_valid = |ready_vec;
  end

  assign alloc_fire = alloc_valid && alloc_ready && !flush;
  assign issue_fire = issue_valid && issue_ready && !flush;
  assign comp_fire  = complete_valid && (state_q[complete_index] == S_ISSUED) && !flush;
  // A dependency on a slot retiring this very edge is already satisfied
  assign alloc_mask = ~free_vec & ~(ONE << alloc_index)
                    & ~(comp_fire ? (ONE << complete_index) : '0);

  always_comb begin
    state_d = state_q;
    dep_d   = dep_q;
    age_d   = age_q;
    if (flush) begin
      for (int i = 0; i < BS; i++) begin
        state_d[i] = S_FREE;
        dep_d[i]   = '0;
        age_d[i]   = '0;
      end
    end else begin
      if (issue_fire) state_d[issue_index] = S_ISSUED;
      if (alloc_fire) begin
        state_d[alloc_index] = S_WAIT;
        dep_d[alloc_index]   = alloc_dep & alloc_mask;
        age_d[alloc_index]   = '0;
        for (int i = 0; i < BS; i++) age_d[i][alloc_index] = !free_vec[i];
      end
      if (comp_fire) begin
        state_d[complete_index] = S_FREE;
        age_d[complete_index]   = '0;
        for (int i = 0; i < BS; i++) begin
          dep_d[i][complete_index] = 1'b0;
          age_d[i][complete_index] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BS; i++) begin
        state_q[i] <= S_FREE;
        dep_q[i]   <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      dep_q   <= dep_d;
      age_q   <= age_d;
    end
  end

`ifdef ESM_SCHED_ERR_EN
  logic err_q;
  logic err_d;

  always_comb begin
    err_d = err_q;
    if (flush) err_d = 1'b0;
    else if ((complete_valid && (state_q[complete_index] != S_ISSUED)) ||
             (alloc_valid && !alloc_ready)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
